// File: rtl/calc_sequencer.sv
// Keypad calculator sequencer: operand entry, add/subtract, double-dabble BCD display.
// Define CALC_MUL_EN to enable keycode C as multiply.
module calc_sequencer #(
    parameter int OPW = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] keycode,
    input  logic       keystrobe,
    output logic [3:0] bcd1,
    output logic [3:0] bcd10,
    output logic [3:0] bcd100,
    output logic       neg,
    output logic       err,
    output logic       busy,
    output logic [2:0] state
);
    typedef enum logic [2:0] {
        ENTER_A = 3'd0,
        ENTER_B = 3'd1,
        COMPUTE = 3'd2,
        CONVERT = 3'd3,
        SHOW    = 3'd4,
        ERROR   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2
    } op_t;

    localparam int CW   = OPW + 12;
    localparam int CNTW = $clog2(OPW + 1);
    localparam int RW   = 2 * OPW;
    localparam logic [OPW-1:0]  LIM_ENTRY = OPW'(99);
    localparam logic [OPW-1:0]  TEN       = OPW'(10);
    localparam logic [RW-1:0]   RES_MAX   = RW'(999);
    localparam logic [CNTW-1:0] CNT_LAST  = CNTW'(OPW - 1);

    // One double-dabble iteration: adjust each BCD nibble >= 5, then shift left.
    function automatic logic [CW-1:0] dabble_step(input logic [CW-1:0] v);
        logic [CW-1:0] t;
        t = v;
        for (int i = 0; i < 3; i++) begin
            if (t[OPW + 4*i +: 4] >= 4'd5) begin
                t[OPW + 4*i +: 4] = t[OPW + 4*i +: 4] + 4'd3;
            end else begin
                t[OPW + 4*i +: 4] = t[OPW + 4*i +: 4];
            end
        end
        return {t[CW-2:0], 1'b0};
    endfunction

    state_t          state_r, state_n;
    op_t             op_r, op_n, key_opc_s;
    logic [OPW-1:0]  a_r, a_n, b_r, b_n, res_r, res_n, digit_ext_s;
    logic [CW-1:0]   conv_r, conv_n;
    logic [CNTW-1:0] cnt_r, cnt_n;
    logic [3:0]      d1_r, d1_n, d10_r, d10_n, d100_r, d100_n;
    logic            neg_r, neg_n, err_r, err_n, busy_r;
    logic            key_digit_s, key_op_s, key_eq_s, key_clr_s;
    logic [RW-1:0]   a_ext_s, b_ext_s, res_s;
    logic            res_neg_s, res_over_s;

    // Key decode; multiply key is only recognised when the feature is built in.
    always_comb begin
        key_digit_s = keystrobe && (keycode <= 4'd9);
        key_eq_s    = keystrobe && (keycode == 4'hE);
        key_clr_s   = keystrobe && (keycode == 4'hF);
        digit_ext_s = {{(OPW-4){1'b0}}, keycode};
        key_op_s    = 1'b0;
        key_opc_s   = OP_ADD;
        case (keycode)
            4'hA: begin key_op_s = keystrobe; key_opc_s = OP_ADD; end
            4'hB: begin key_op_s = keystrobe; key_opc_s = OP_SUB; end
`ifdef CALC_MUL_EN
            4'hC: begin key_op_s = keystrobe; key_opc_s = OP_MUL; end
`endif
            default: begin key_op_s = 1'b0; key_opc_s = OP_ADD; end
        endcase
    end

    // Arithmetic unit; subtraction yields magnitude plus sign.
    always_comb begin
        a_ext_s   = {{OPW{1'b0}}, a_r};
        b_ext_s   = {{OPW{1'b0}}, b_r};
        res_s     = a_ext_s + b_ext_s;
        res_neg_s = 1'b0;
        case (op_r)
            OP_SUB: begin
                if (a_r >= b_r) begin
                    res_s = a_ext_s - b_ext_s;
                end else begin
                    res_s     = b_ext_s - a_ext_s;
                    res_neg_s = 1'b1;
                end
            end
`ifdef CALC_MUL_EN
            OP_MUL: res_s = a_ext_s * b_ext_s;
`endif
            default: res_s = a_ext_s + b_ext_s;
        endcase
        res_over_s = (res_s > RES_MAX);
    end

    // Next-state and next-datapath logic; clear key overrides everything.
    always_comb begin
        state_n = state_r;
        op_n    = op_r;
        a_n     = a_r;
        b_n     = b_r;
        res_n   = res_r;
        conv_n  = conv_r;
        cnt_n   = cnt_r;
        neg_n   = neg_r;
        err_n   = err_r;
        d1_n    = d1_r;
        d10_n   = d10_r;
        d100_n  = d100_r;
        case (state_r)
            ENTER_A: begin
                if (key_digit_s) begin
                    if (a_r <= LIM_ENTRY) begin
                        a_n    = a_r * TEN + digit_ext_s;
                        d100_n = d10_r;
                        d10_n  = d1_r;
                        d1_n   = keycode;
                    end else begin
                        a_n = a_r;
                    end
                end else if (key_op_s) begin
                    op_n    = key_opc_s;
                    b_n     = {OPW{1'b0}};
                    {d100_n, d10_n, d1_n} = 12'h000;
                    state_n = ENTER_B;
                end else begin
                    state_n = ENTER_A;
                end
            end
            ENTER_B: begin
                if (key_digit_s) begin
                    if (b_r <= LIM_ENTRY) begin
                        b_n    = b_r * TEN + digit_ext_s;
                        d100_n = d10_r;
                        d10_n  = d1_r;
                        d1_n   = keycode;
                    end else begin
                        b_n = b_r;
                    end
                end else if (key_op_s) begin
                    op_n = key_opc_s;
                end else if (key_eq_s) begin
                    state_n = COMPUTE;
                end else begin
                    state_n = ENTER_B;
                end
            end
            COMPUTE: begin
                res_n = res_s[OPW-1:0];
                neg_n = res_neg_s;
                if (res_over_s) begin
                    err_n   = 1'b1;
                    {d100_n, d10_n, d1_n} = 12'hEEE;
                    state_n = ERROR;
                end else begin
                    conv_n  = {12'h000, res_s[OPW-1:0]};
                    cnt_n   = {CNTW{1'b0}};
                    state_n = CONVERT;
                end
            end
            CONVERT: begin
                conv_n = dabble_step(conv_r);
                cnt_n  = cnt_r + 1'b1;
                if (cnt_r == CNT_LAST) begin
                    state_n = SHOW;
                end else begin
                    state_n = CONVERT;
                end
            end
            SHOW: begin
                if (key_digit_s) begin
                    a_n     = digit_ext_s;
                    neg_n   = 1'b0;
                    {d100_n, d10_n, d1_n} = {8'h00, keycode};
                    state_n = ENTER_A;
                end else if (key_op_s && !neg_r) begin
                    a_n     = res_r;
                    op_n    = key_opc_s;
                    b_n     = {OPW{1'b0}};
                    {d100_n, d10_n, d1_n} = 12'h000;
                    state_n = ENTER_B;
                end else begin
                    d1_n   = conv_r[OPW +: 4];
                    d10_n  = conv_r[OPW + 4 +: 4];
                    d100_n = conv_r[OPW + 8 +: 4];
                end
            end
            ERROR: begin
                {d100_n, d10_n, d1_n} = 12'hEEE;
            end
            default: begin
                state_n = ENTER_A;
            end
        endcase
        if (key_clr_s) begin
            state_n = ENTER_A;
            op_n    = OP_ADD;
            a_n     = {OPW{1'b0}};
            b_n     = {OPW{1'b0}};
            conv_n  = {CW{1'b0}};
            neg_n   = 1'b0;
            err_n   = 1'b0;
            {d100_n, d10_n, d1_n} = 12'h000;
        end else begin
            err_n = err_n;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ENTER_A;
            op_r    <= OP_ADD;
            a_r     <= {OPW{1'b0}};
            b_r     <= {OPW{1'b0}};
            res_r   <= {OPW{1'b0}};
            conv_r  <= {CW{1'b0}};
            cnt_r   <= {CNTW{1'b0}};
            neg_r   <= 1'b0;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
            d1_r    <= 4'h0;
            d10_r   <= 4'h0;
            d100_r  <= 4'h0;
        end else begin
            state_r <= state_n;
            op_r    <= op_n;
            a_r     <= a_n;
            b_r     <= b_n;
            res_r   <= res_n;
            conv_r  <= conv_n;
            cnt_r   <= cnt_n;
            neg_r   <= neg_n;
            err_r   <= err_n;
            busy_r  <= (state_n == COMPUTE) || (state_n == CONVERT);
            d1_r    <= d1_n;
            d10_r   <= d10_n;
            d100_r  <= d100_n;
        end
    end

    assign bcd1   = d1_r;
    assign bcd10  = d10_r;
    assign bcd100 = d100_r;
    assign neg    = neg_r;
    assign err    = err_r;
    assign busy   = busy_r;
    assign state  = state_r;

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: directed key sequences plus random keys against a value-level model.
module tb_calc_sequencer;
    localparam int OPW = 10;
`ifdef CALC_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] keycode = 4'h0;
    logic       keystrobe = 1'b0;
    logic [3:0] bcd1, bcd10, bcd100;
    logic       neg, err, busy;
    logic [2:0] state;

    int n_vec = 0;
    int n_bad = 0;

    // Model: phase 0 entering A, 1 entering B, 2 busy, 3 showing, 4 error.
    int m_phase, m_a, m_b, m_op, m_res, m_k, m_disp;
    bit m_neg, m_rneg, m_over;

    logic [3:0] kq[$];

    calc_sequencer #(.OPW(OPW)) dut (
        .clock(clock), .reset(reset), .keycode(keycode), .keystrobe(keystrobe),
        .bcd1(bcd1), .bcd10(bcd10), .bcd100(bcd100),
        .neg(neg), .err(err), .busy(busy), .state(state)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic bit is_op(input int k);
        return (k == 10) || (k == 11) || (MUL_ON && (k == 12));
    endfunction

    task automatic model_reset();
        m_phase = 0; m_a = 0; m_b = 0; m_op = 10; m_res = 0;
        m_k = 0; m_disp = 0; m_neg = 1'b0; m_rneg = 1'b0; m_over = 1'b0;
    endtask

    task automatic model_edge(input bit v, input int key);
        int r;
        if (v && key == 15) begin
            model_reset();
        end else begin
            case (m_phase)
                0: begin
                    if (v && key <= 9) begin
                        if (m_a <= 99) m_a = m_a * 10 + key;
                        m_disp = m_a;
                    end else if (v && is_op(key)) begin
                        m_op = key; m_b = 0; m_disp = 0; m_phase = 1;
                    end
                end
                1: begin
                    if (v && key <= 9) begin
                        if (m_b <= 99) m_b = m_b * 10 + key;
                        m_disp = m_b;
                    end else if (v && is_op(key)) begin
                        m_op = key;
                    end else if (v && key == 14) begin
                        m_rneg = 1'b0;
                        if (m_op == 11) begin
                            if (m_a >= m_b) r = m_a - m_b;
                            else begin r = m_b - m_a; m_rneg = 1'b1; end
                        end else if (m_op == 12) begin
                            r = m_a * m_b;
                        end else begin
                            r = m_a + m_b;
                        end
                        m_res = r; m_over = (r > 999); m_k = 0; m_phase = 2;
                    end
                end
                2: begin
                    m_k++;
                    if (m_k == 1) begin
                        m_neg = m_rneg;
                        if (m_over) begin m_phase = 4; m_disp = -1; end
                    end
                    if (m_phase == 2 && m_k == OPW + 1) m_phase = 3;
                end
                3: begin
                    if (v && key <= 9) begin
                        m_a = key; m_neg = 1'b0; m_disp = key; m_phase = 0;
                    end else if (v && is_op(key) && !m_neg) begin
                        m_a = m_res; m_op = key; m_b = 0; m_disp = 0; m_phase = 1;
                    end else begin
                        m_disp = m_res;
                    end
                end
                default: ;
            endcase
        end
    endtask

    function automatic logic [14:0] exp_vec();
        logic [3:0] h, t, u;
        if (m_disp < 0) begin
            h = 4'hE; t = 4'hE; u = 4'hE;
        end else begin
            h = 4'(m_disp / 100); t = 4'((m_disp / 10) % 10); u = 4'(m_disp % 10);
        end
        return {h, t, u, m_neg, (m_phase == 4), (m_phase == 2)};
    endfunction

    task automatic tick(input bit v, input logic [3:0] key);
        keystrobe = v;
        keycode = key;
        @(posedge clock);
        model_edge(v, int'(key));
        @(negedge clock);
        keystrobe = 1'b0;
        check_val("cycle", {17'd0, bcd100, bcd10, bcd1, neg, err, busy}, {17'd0, exp_vec()});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 4'h0);
    endtask

    task automatic run_kq();
        foreach (kq[i]) begin
            tick(1'b1, kq[i]);
            tick(1'b0, 4'h0);
        end
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b1;
        #1 model_reset();
        check_val("rst_async", {17'd0, bcd100, bcd10, bcd1, neg, err, busy}, 32'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        int bc, first_k, r, sel;
        logic [3:0] key;
        model_reset();
        #1 reset = 1'b1;
        @(negedge clock);
        check_val("rst_init", {17'd0, bcd100, bcd10, bcd1, neg, err, busy}, 32'd0);
        reset = 1'b0;

        // 123 + 45 = 168, busy window and display latency
        kq = '{4'd1, 4'd2, 4'd3, 4'hA, 4'd4, 4'd5};
        run_kq();
        tick(1'b1, 4'hE);
        bc = busy ? 1 : 0;
        first_k = -1;
        for (int i = 1; i <= 20; i++) begin
            tick(1'b0, 4'h0);
            if (busy) bc++;
            if (first_k < 0 && {bcd100, bcd10, bcd1} == 12'h168) first_k = i;
        end
        check_val("busy_len", bc, OPW + 1);
        check_val("latency", first_k, OPW + 2);
        check_val("sum168", {bcd100, bcd10, bcd1, neg}, {12'h168, 1'b0});

        // 5 - 12 = -7, operator ignored while negative, digit returns to entry
        kq = '{4'hF, 4'd5, 4'hB, 4'd1, 4'd2, 4'hE};
        run_kq();
        idle(14);
        check_val("neg007", {bcd100, bcd10, bcd1, neg}, {12'h007, 1'b1});
        kq = '{4'hA};
        run_kq();
        check_val("neg_op_ign", {bcd100, bcd10, bcd1, neg, busy}, {12'h007, 2'b10});
        kq = '{4'd4};
        run_kq();
        check_val("show_digit", {bcd100, bcd10, bcd1, neg}, {12'h004, 1'b0});

        // 999 + 1 overflows
        kq = '{4'hF, 4'd9, 4'd9, 4'd9, 4'hA, 4'd1, 4'hE};
        run_kq();
        idle(3);
        check_val("err_eee", {bcd100, bcd10, bcd1, err}, {12'hEEE, 1'b1});
        kq = '{4'd3};
        run_kq();
        check_val("err_digit", {bcd100, bcd10, bcd1, err}, {12'hEEE, 1'b1});
        kq = '{4'hF};
        run_kq();
        check_val("err_clear", {bcd100, bcd10, bcd1, err}, {12'h000, 1'b0});

        // fourth digit ignored, then reset during conversion
        kq = '{4'd1, 4'd2, 4'd3, 4'd4};
        run_kq();
        check_val("entry123", {bcd100, bcd10, bcd1}, 12'h123);
        kq = '{4'hF, 4'd1, 4'hA, 4'd1};
        run_kq();
        tick(1'b1, 4'hE);
        idle(3);
        pulse_reset();
        idle(15);
        check_val("post_rst", {bcd100, bcd10, bcd1, busy}, 13'h0000);

`ifdef CALC_MUL_EN
        kq = '{4'd3, 4'd2, 4'hC, 4'd3, 4'd1, 4'hE};
        run_kq();
        idle(14);
        check_val("mul992", {bcd100, bcd10, bcd1, neg}, {12'h992, 1'b0});
        kq = '{4'hA, 4'd8, 4'hE};
        run_kq();
        idle(3);
        check_val("mul_err", {bcd100, bcd10, bcd1, err}, {12'hEEE, 1'b1});
`else
        kq = '{4'hF, 4'd3, 4'd2, 4'hC, 4'd3};
        run_kq();
        check_val("c_ignored", {bcd100, bcd10, bcd1}, 12'h323);
`endif
        kq = '{4'hF};
        run_kq();

        for (int c = 0; c < 5000; c++) begin
            r = $urandom_range(0, 999);
            if (r < 2) begin
                pulse_reset();
            end else if (r < 450) begin
                tick(1'b0, 4'h0);
            end else begin
                sel = $urandom_range(0, 99);
                if (sel < 50)      key = 4'($urandom_range(0, 9));
                else if (sel < 65) key = 4'hA;
                else if (sel < 75) key = 4'hB;
                else if (sel < 82) key = 4'hC;
                else if (sel < 85) key = 4'hD;
                else if (sel < 96) key = 4'hE;
                else               key = 4'hF;
                tick(1'b1, key);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
